// File: rtl/svm_feature_packer_if.sv
// Bundle between the byte producer, the packer and the classifier-side FIFO reader.
// Handshakes: a byte moves on a rising edge when in_valid && in_ready; a word is popped
// on a rising edge when rdfifo && !rdempty. rddata is valid whenever rdempty is low.
interface svm_feature_packer_if #(
    parameter int LVL_W = 5
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [127:0]     rddata;
    logic             rdempty;
    logic             rdfifo;
    logic [LVL_W-1:0] fifo_level;
    logic             vec_done;
    logic             pad_event;
    logic             underflow_err;
    logic             dbg_pad;

    modport slave (
        input  in_data, in_valid, in_last, rdfifo,
        output in_ready, rddata, rdempty, fifo_level, vec_done, pad_event,
               underflow_err, dbg_pad
    );

    modport master (
        output in_data, in_valid, in_last, rdfifo,
        input  in_ready, rddata, rdempty, fifo_level, vec_done, pad_event,
               underflow_err, dbg_pad
    );
endinterface

// File: rtl/svm_feature_packer.sv
// Packs a feature byte stream into 128-bit little-endian words, pads short vectors to
// VECTOR_WORDS words with zeros, and buffers the words in a first-word-fall-through FIFO.
module svm_feature_packer #(
    parameter int DEPTH        = 16,
    parameter int VECTOR_WORDS = 512,
    parameter int LVL_W        = 5
) (
    input logic                  clk,
    input logic                  reset,
    svm_feature_packer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (VECTOR_WORDS > 1) ? $clog2(VECTOR_WORDS) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [CW-1:0]    LAST_WORD = CW'(VECTOR_WORDS - 1);

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       byte_idx;
    logic [127:0]     word_buf;
    logic [127:0]     fill_word;
    logic [127:0]     push_data;
    logic [CW-1:0]    word_cnt;
    logic [127:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level;
    logic             not_full;
    logic             empty;
    logic             in_ready;
    logic             accept;
    logic             push;
    logic             pop;
    logic             vec_end;
    logic             start_pad;
    logic             vec_done_q;
    logic             pad_event_q;
    logic             underflow_q;

    assign not_full = level < FULL_LVL;
    assign empty    = (level == '0);
    assign pop      = bus.rdfifo && !empty;
    assign vec_end  = (word_cnt == LAST_WORD);
    assign accept   = bus.in_valid && in_ready;

    // word_buf is cleared after every push, so unfilled bytes of a partial word are zero.
    always_comb begin
        fill_word = word_buf;
        fill_word[{byte_idx, 3'b000} +: 8] = bus.in_data;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        push       = 1'b0;
        push_data  = word_buf;
        start_pad  = 1'b0;
        case (state)
            FILL: begin
                in_ready = not_full && !reset;
                if (bus.in_valid && in_ready) begin
                    push      = (byte_idx == 4'd15);
                    push_data = fill_word;
                    if (bus.in_last && !(push && vec_end)) begin
                        state_next = PAD;
                        start_pad  = 1'b1;
                    end
                end
            end
            PAD: begin
                push = not_full;
                if (push && vec_end) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            byte_idx    <= '0;
            word_buf    <= '0;
            word_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            vec_done_q  <= 1'b0;
            pad_event_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state <= state_next;
            if (push) begin
                byte_idx <= '0;
                word_buf <= '0;
                word_cnt <= vec_end ? '0 : word_cnt + 1'b1;
                wr_ptr   <= wr_ptr + 1'b1;
            end else if (accept) begin
                byte_idx <= byte_idx + 1'b1;
                word_buf <= fill_word;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            vec_done_q  <= push && vec_end;
            pad_event_q <= start_pad;
            if (bus.rdfifo && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.rddata        = empty ? '0 : mem[rd_ptr];
    assign bus.rdempty       = empty;
    assign bus.fifo_level    = level;
    assign bus.vec_done      = vec_done_q;
    assign bus.pad_event     = pad_event_q;
    assign bus.underflow_err = underflow_q;
    assign bus.dbg_pad       = (state == PAD);
endmodule

// File: tb/tb_svm_feature_packer.sv
// Bench for svm_feature_packer: random byte streams against a word-list reference model.
module tb_svm_feature_packer;
    localparam int DEPTH   = 16;
    localparam int VW      = 512;
    localparam int LVL_W   = 5;
    localparam int TIMEOUT = 4000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    svm_feature_packer_if #(.LVL_W(LVL_W)) bus();

    svm_feature_packer #(
        .DEPTH(DEPTH),
        .VECTOR_WORDS(VW),
        .LVL_W(LVL_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int vec_cnt = 0;
    int pad_cnt = 0;
    int pad_ready_viol = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   src_q[$];
    bit           last_q[$];

    // Event monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.vec_done) vec_cnt++;
            if (bus.pad_event) pad_cnt++;
            if (bus.dbg_pad && bus.in_ready) pad_ready_viol++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stream();
        src_q.delete();
        last_q.delete();
        exp_q.delete();
        vec_cnt = 0;
        pad_cnt = 0;
        pad_ready_viol = 0;
    endtask

    task automatic add_random(input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(8'($urandom_range(0, 255)));
            last_q.push_back(last_on_final && (i == n - 1));
        end
    endtask

    // Reference: chunk bytes into 16-byte words (byte k at bits 8k+7:8k); on a last byte,
    // flush the partial word zero-filled and add zero words up to a multiple of VW.
    task automatic model_build();
        logic [127:0] w;
        int nb;
        int nw;
        w = '0;
        nb = 0;
        nw = 0;
        exp_q.delete();
        for (int i = 0; i < src_q.size(); i++) begin
            w[8*nb +: 8] = src_q[i];
            nb++;
            if (nb == 16) begin
                exp_q.push_back(w);
                w = '0;
                nb = 0;
                nw++;
            end
            if (last_q[i]) begin
                if (nb > 0) begin
                    exp_q.push_back(w);
                    w = '0;
                    nb = 0;
                    nw++;
                end
                while (nw % VW != 0) begin
                    exp_q.push_back('0);
                    nw++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = 8'h00;
        bus.rdfifo = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_range(input int lo, input int hi, input bit stalls);
        int w;
        @(negedge clk);
        for (int i = lo; i < hi; i++) begin
            if (stalls && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data = src_q[i];
            bus.in_last = last_q[i];
            w = 0;
            #1;
            while (!bus.in_ready && w < TIMEOUT) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (!bus.in_ready) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: byte %0d not accepted, in_ready=%b required 1", i, bus.in_ready);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    // Must be entered at a negedge; each pop holds rdfifo for one cycle.
    task automatic pop_words(input int n, input int gap);
        int w;
        logic [127:0] exp;
        for (int i = 0; i < n; i++) begin
            #1;
            w = 0;
            while (bus.rdempty && w < TIMEOUT) begin
                @(negedge clk);
                #1;
                w++;
            end
            checks++;
            if (bus.rdempty) begin
                failures++;
                $display("FAIL rdempty_timeout: word %0d never appeared, rdempty=%b required 0", i, bus.rdempty);
                return;
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL extra_word: got %h required no word", bus.rddata);
                return;
            end
            exp = exp_q.pop_front();
            if (bus.rddata !== exp) begin
                failures++;
                $display("FAIL rddata word %0d: got %h required %h", i, bus.rddata, exp);
            end
            bus.rdfifo = 1'b1;
            @(negedge clk);
            bus.rdfifo = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_drained();
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus.rdempty !== 1'b1) begin
            failures++;
            $display("FAIL drained_rdempty: got %b required 1", bus.rdempty);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drained_model: got %0d words left required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        bus.in_data = 8'h00;
        bus.rdfifo = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL reset_rdempty: got %b required 1", bus.rdempty); end
        checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d required 0", bus.fifo_level); end
        checks++; if (bus.vec_done !== 1'b0) begin failures++; $display("FAIL reset_vec_done: got %b required 0", bus.vec_done); end
        checks++; if (bus.pad_event !== 1'b0) begin failures++; $display("FAIL reset_pad_event: got %b required 0", bus.pad_event); end
        checks++; if (bus.underflow_err !== 1'b0) begin failures++; $display("FAIL reset_underflow: got %b required 0", bus.underflow_err); end
        checks++; if (bus.rddata !== 128'd0) begin failures++; $display("FAIL reset_rddata: got %h required 0", bus.rddata); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b required 1", bus.in_ready); end
    endtask

    task automatic test_first_word();
        do_reset();
        clear_stream();
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(8'(i));
            last_q.push_back(1'b0);
        end
        model_build();
        drive_range(0, 15, 1'b0);
        #1;
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL first_word_early: rdempty got %b required 1", bus.rdempty); end
        drive_range(15, 16, 1'b0);
        #1;
        checks++; if (bus.rdempty !== 1'b0) begin failures++; $display("FAIL first_word_rdempty: got %b required 0", bus.rdempty); end
        checks++; if (bus.rddata !== 128'h0F0E0D0C0B0A09080706050403020100) begin failures++; $display("FAIL first_word_data: got %h required 0f0e0d0c0b0a09080706050403020100", bus.rddata); end
        checks++; if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL first_word_level: got %0d required 1", bus.fifo_level); end
        @(negedge clk);
        pop_words(1, 0);
        check_drained();
    endtask

    task automatic test_full_vector();
        do_reset();
        clear_stream();
        add_random(VW * 16, 1'b1);
        model_build();
        fork
            drive_range(0, src_q.size(), 1'b1);
            begin
                @(negedge clk);
                pop_words(VW, 1);
            end
        join
        check_drained();
        checks++; if (vec_cnt != 1) begin failures++; $display("FAIL full_vec_done: got %0d required 1", vec_cnt); end
        checks++; if (pad_cnt != 0) begin failures++; $display("FAIL full_pad_event: got %0d required 0", pad_cnt); end
    endtask

    task automatic test_pad(input bit fixed);
        do_reset();
        clear_stream();
        if (fixed) begin
            src_q.push_back(8'h00); last_q.push_back(1'b0);
            src_q.push_back(8'h01); last_q.push_back(1'b0);
            src_q.push_back(8'h02); last_q.push_back(1'b1);
        end else begin
            add_random(16 * 3 + 7, 1'b1);
        end
        model_build();
        fork
            drive_range(0, src_q.size(), !fixed);
            begin
                @(negedge clk);
                pop_words(VW, 0);
            end
        join
        check_drained();
        checks++; if (pad_cnt != 1) begin failures++; $display("FAIL pad_event_count: got %0d required 1", pad_cnt); end
        checks++; if (vec_cnt != 1) begin failures++; $display("FAIL pad_vec_done: got %0d required 1", vec_cnt); end
        checks++; if (pad_ready_viol != 0) begin failures++; $display("FAIL pad_in_ready: got %0d cycles with in_ready=1 required 0", pad_ready_viol); end
    endtask

    task automatic test_backpressure();
        int w;
        logic [127:0] exp;
        do_reset();
        clear_stream();
        add_random(16 * DEPTH + 5, 1'b0);
        model_build();
        fork
            drive_range(0, src_q.size(), 1'b0);
            begin
                w = 0;
                @(negedge clk);
                #1;
                while (bus.fifo_level !== 5'd16 && w < TIMEOUT) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                checks++; if (bus.fifo_level !== 5'd16) begin failures++; $display("FAIL bp_full_level: got %0d required 16", bus.fifo_level); end
                repeat (8) @(negedge clk);
                #1;
                checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b required 0", bus.in_ready); end
                checks++; if (bus.fifo_level !== 5'd16) begin failures++; $display("FAIL bp_level_hold: got %0d required 16", bus.fifo_level); end
                exp = exp_q.pop_front();
                checks++; if (bus.rddata !== exp) begin failures++; $display("FAIL bp_first_word: got %h required %h", bus.rddata, exp); end
                bus.rdfifo = 1'b1;
                @(posedge clk);
                #1;
                checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after_pop: got %b required 1", bus.in_ready); end
                @(negedge clk);
                bus.rdfifo = 1'b0;
                pop_words(DEPTH - 1, 1);
            end
        join
        check_drained();
    endtask

    task automatic test_underflow();
        do_reset();
        clear_stream();
        bus.rdfifo = 1'b1;
        @(negedge clk);
        bus.rdfifo = 1'b0;
        #1;
        checks++; if (bus.underflow_err !== 1'b1) begin failures++; $display("FAIL underflow_set: got %b required 1", bus.underflow_err); end
        checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL underflow_level: got %0d required 0", bus.fifo_level); end
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL underflow_rdempty: got %b required 1", bus.rdempty); end
        add_random(16, 1'b0);
        model_build();
        drive_range(0, 16, 1'b1);
        pop_words(1, 0);
        check_drained();
        checks++; if (bus.underflow_err !== 1'b1) begin failures++; $display("FAIL underflow_sticky: got %b required 1", bus.underflow_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_stream();
        add_random(16 * 6, 1'b0);
        model_build();
        drive_range(0, src_q.size(), 1'b0);
        #1;
        checks++; if (bus.fifo_level !== 5'd6) begin failures++; $display("FAIL b2b_level: got %0d required 6", bus.fifo_level); end
        @(negedge clk);
        pop_words(6, 0);
        check_drained();
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_stream();
        add_random(16 * 3 + 7, 1'b0);
        drive_range(0, src_q.size(), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.rdempty !== 1'b1) begin failures++; $display("FAIL mid_reset_rdempty: got %b required 1", bus.rdempty); end
        checks++; if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL mid_reset_level: got %0d required 0", bus.fifo_level); end
        @(negedge clk);
        reset = 1'b0;
        clear_stream();
        add_random(16, 1'b1);
        model_build();
        fork
            drive_range(0, src_q.size(), 1'b0);
            begin
                @(negedge clk);
                pop_words(VW, 0);
            end
        join
        check_drained();
        checks++; if (pad_cnt != 1) begin failures++; $display("FAIL mid_pad_event: got %0d required 1", pad_cnt); end
        checks++; if (vec_cnt != 1) begin failures++; $display("FAIL mid_vec_done: got %0d required 1", vec_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_full_vector();
        test_pad(1'b1);
        test_pad(1'b0);
        test_backpressure();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
